button_debounce_pulse: RTL and testbench



---
 rtl/button_debounce_pulse.sv | 152 +++++++++++++++
 tb/tb_button_debounce_pulse.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, counter-based debounce FSM,
// registered level and one-cycle press pulse. Hold-to-repeat under BUTTON_DEBOUNCE_AUTO_REPEAT_EN.
module button_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic          act;
    logic          sync1_q;
    logic          sync2_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;

`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
    localparam int            RPT_MAX     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int            RPW         = $clog2(RPT_MAX + 1);
    localparam logic [RPW-1:0] HOLD_LAST   = RPW'(HOLD_CYCLES - 1);
    localparam logic [RPW-1:0] REPEAT_LAST = RPW'(REPEAT_CYCLES - 1);

    logic [RPW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic           rpt_phase_q, rpt_phase_d;
    logic [RPW-1:0] rpt_target;

    // First repeat waits the hold time, later ones the shorter repeat period.
    assign rpt_target = rpt_phase_q ? REPEAT_LAST : HOLD_LAST;
`endif

    assign act = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= act;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`endif

    // A change of sync2 always wins over the counter reaching its terminal value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_phase_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
                else if (rpt_cnt_q == rpt_target) begin
                    pulse_d     = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_phase_d = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Scoreboard bench for button_debounce_pulse: stimulus queues expected pulse edges
// and level changes; a negedge monitor pops and compares whenever the DUT outputs move.
module tb_button_debounce_pulse;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int RPT  = 4;

    typedef struct {
        int   edge_n;
        logic val;
    } lvl_exp_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic btn_raw = 1'b1;
    logic btn_level;
    logic btn_pulse;

    int       cyc    = 0;
    int       n_cmp  = 0;
    int       n_bad  = 0;
    int       base   = 0;
    int       pulse_q[$];
    lvl_exp_t lvl_q[$];
    logic     prev_level = 1'b0;

    button_debounce_pulse #(
        .DEBOUNCE_CYCLES(DB),
        .BTN_ACTIVE_LOW (1'b1),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_bit(input string name, input logic act_v, input logic exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b (edge %0d)", name, act_v, exp_v, cyc);
        end else begin
            $display("ok   %s: %b (edge %0d)", name, act_v, cyc);
        end
    endtask

    task automatic push_lvl(input int e, input logic v);
        lvl_exp_t x;
        x.edge_n = e;
        x.val    = v;
        lvl_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every observed pulse and every level change consumes one expectation.
    always @(negedge clk) begin
        int       e;
        lvl_exp_t x;
        if (btn_pulse === 1'b1) begin
            n_cmp++;
            if (pulse_q.size() == 0) begin
                n_bad++;
                $display("FAIL pulse_unexpected: pulse at edge %0d, required none", cyc);
            end else begin
                e = pulse_q.pop_front();
                if (e != cyc) begin
                    n_bad++;
                    $display("FAIL pulse_edge: pulse at edge %0d, required edge %0d", cyc, e);
                end else begin
                    $display("ok   pulse_edge: pulse at edge %0d", cyc);
                end
            end
        end
        if (btn_level !== prev_level) begin
            n_cmp++;
            if (lvl_q.size() == 0) begin
                n_bad++;
                $display("FAIL level_unexpected: level %b at edge %0d, required no change", btn_level, cyc);
            end else begin
                x = lvl_q.pop_front();
                if (x.edge_n != cyc || btn_level !== x.val) begin
                    n_bad++;
                    $display("FAIL level_edge: level %b at edge %0d, required %b at edge %0d",
                             btn_level, cyc, x.val, x.edge_n);
                end else begin
                    $display("ok   level_edge: level %b at edge %0d", btn_level, cyc);
                end
            end
        end
        prev_level = btn_level;
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check_bit("reset_level", btn_level, 1'b0);
        check_bit("reset_pulse", btn_pulse, 1'b0);
        step(2);
        rst_n = 1'b1;

        // Released key for 100 cycles: nothing happens
        step(100);
        check_bit("idle_level", btn_level, 1'b0);

        // Clean press held 20 cycles, then clean release
        base    = cyc;
        btn_raw = 1'b0;
        pulse_q.push_back(base + 7);
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
        pulse_q.push_back(base + 15);
        pulse_q.push_back(base + 19);
`endif
        push_lvl(base + 7, 1'b1);
        step(20);
        btn_raw = 1'b1;
        push_lvl(cyc + 7, 1'b0);
        step(12);

        // Short glitch rejected
        btn_raw = 1'b0;
        step(3);
        btn_raw = 1'b1;
        step(12);
        check_bit("glitch_level", btn_level, 1'b0);

        // Release bounce while pressed: no second pulse, level held
        base    = cyc;
        btn_raw = 1'b0;
        pulse_q.push_back(base + 7);
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
        pulse_q.push_back(base + 18);
        pulse_q.push_back(base + 22);
`endif
        push_lvl(base + 7, 1'b1);
        step(10);
        btn_raw = 1'b1;
        step(2);
        btn_raw = 1'b0;
        step(8);
        check_bit("bounce_level", btn_level, 1'b1);
        btn_raw = 1'b1;
        push_lvl(cyc + 7, 1'b0);
        step(12);

        // Async reset mid-PRESS_WAIT, key still held afterwards
        btn_raw = 1'b0;
        step(4);
        #2 rst_n = 1'b0;
        #1;
        check_bit("rst_pw_level", btn_level, 1'b0);
        check_bit("rst_pw_pulse", btn_pulse, 1'b0);
        step(1);
        rst_n = 1'b1;
        base  = cyc;
        pulse_q.push_back(base + 7);
        push_lvl(base + 7, 1'b1);
        step(12);
        btn_raw = 1'b1;
        push_lvl(cyc + 7, 1'b0);
        step(12);

        // Async reset while pressed clears outputs before the next edge
        base    = cyc;
        btn_raw = 1'b0;
        pulse_q.push_back(base + 7);
        push_lvl(base + 7, 1'b1);
        step(7);
        #2 rst_n = 1'b0;
        #1;
        check_bit("rst_pr_level", btn_level, 1'b0);
        check_bit("rst_pr_pulse", btn_pulse, 1'b0);
        push_lvl(base + 8, 1'b0);
        step(2);
        btn_raw = 1'b1;
        rst_n   = 1'b1;
        step(12);

        // Long hold: single pulse, or hold-then-repeat pulses
        base    = cyc;
        btn_raw = 1'b0;
        pulse_q.push_back(base + 7);
`ifdef BUTTON_DEBOUNCE_AUTO_REPEAT_EN
        for (int k = 15; k <= 39; k += 4) pulse_q.push_back(base + k);
`endif
        push_lvl(base + 7, 1'b1);
        step(40);
        btn_raw = 1'b1;
        push_lvl(cyc + 7, 1'b0);
        step(12);

        // Drain: anything still queued was never produced
        for (int t = 0; t < 50 && (pulse_q.size() != 0 || lvl_q.size() != 0); t++) step(1);
        while (pulse_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_missing: no pulse seen, required at edge %0d", pulse_q.pop_front());
        end
        while (lvl_q.size() != 0) begin
            lvl_exp_t x;
            x = lvl_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL level_missing: no change seen, required %b at edge %0d", x.val, x.edge_n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
